// File: rtl/bram_vector_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_vector_loader_pkg
// Description : Loader FSM state type and per-operand default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_vector_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  localparam int LOADER_DATA_WIDTH = 8;

  // Weight-operand instance geometry
  localparam int W_DEPTH  = 16;
  localparam int W_ADDR_W = 10;

  // Attention-vector operand instance geometry
  localparam int A_DEPTH  = 16;
  localparam int A_ADDR_W = 10;

endpackage
`default_nettype wire

// File: rtl/bram_vector_loader_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram_vector_loader_lat_pipe
// Description : LATENCY-deep valid+index shift register that follows each
//               issued BRAM read until its data appears on the read port.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_vector_loader_lat_pipe
  import bram_vector_loader_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [LATENCY-1:0] valid_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign idx_o   = idx_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/bram_vector_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram_vector_loader
// Description : Fetches DEPTH consecutive BRAM words from a runtime base into a
//               register array exposed as a flat vector and random-access
//               read ports. LOADER_CHECKSUM_EN adds a running word sum output.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_vector_loader
  import bram_vector_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = LOADER_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 10,
  parameter int BRAM_LATENCY = 2,
  parameter int NUM_RD_PORTS = 4,
  parameter int IDX_W        = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_valid_i,
  input  logic [ADDR_W-1:0]                  base_addr_i,
  output logic                               ready_o,
  output logic                               busy_o,
  output logic                               bram_enb,
  output logic [ADDR_W-1:0]                  bram_addrb,
  input  logic [DATA_WIDTH-1:0]              bram_dout,
  output logic [DEPTH*DATA_WIDTH-1:0]        vec_o,
  input  logic [NUM_RD_PORTS*IDX_W-1:0]      rd_idx_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH+$clog2(DEPTH)-1:0] checksum_o
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam int               EXT_N    = 2 ** IDX_W;

  loader_state_e           state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    start_load;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [DATA_WIDTH-1:0]   arr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   arr_ext [EXT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    start_load = 1'b0;
    bram_enb   = 1'b0;
    bram_addrb = '0;
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          base_d     = base_addr_i;
          cnt_d      = '0;
          start_load = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        bram_enb   = 1'b1;
        bram_addrb = base_q + ADDR_W'(cnt_q);
        busy_o     = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        // Reads return in issue order, so the last index marks completion.
        if (wr_en && (wr_idx == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ready_o = 1'b1;
        if (!load_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bram_vector_loader_lat_pipe #(
    .LATENCY (BRAM_LATENCY),
    .IDX_W   (IDX_W)
  ) u_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (bram_enb),
    .idx_i   (cnt_q),
    .valid_o (wr_en),
    .idx_o   (wr_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          arr_q[i] <= bram_dout;
        end
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_vec
    assign vec_o[i*DATA_WIDTH +: DATA_WIDTH] = arr_q[i];
  end

  // Pad the array to the full index range so out-of-range reads return zero.
  for (genvar i = 0; i < EXT_N; i++) begin : g_ext
    if (i < DEPTH) begin : g_live
      assign arr_ext[i] = arr_q[i];
    end else begin : g_pad
      assign arr_ext[i] = '0;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = arr_ext[rd_idx_i[p*IDX_W +: IDX_W]];
  end

`ifdef LOADER_CHECKSUM_EN
  localparam int CS_W = DATA_WIDTH + $clog2(DEPTH);
  logic [CS_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_load) begin
      csum_q <= '0;
    end else if (wr_en) begin
      csum_q <= csum_q + CS_W'(bram_dout);
    end
  end

  assign checksum_o = csum_q;
`endif

endmodule
`default_nettype wire
